// File: rtl/duration_scan_controller.sv
// rtl/duration_scan_controller.sv - round-robin period/high-time scanner sharing one counter
// Optional DURATION_SCAN_DONE_EN adds scan_done, a pulse on the last enabled channel's handshake.
module duration_scan_controller #(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 100000000,
  parameter int CH_W     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] d,
  input  logic [CHANNELS-1:0] enable_mask,
  input  logic                run,
  input  logic                result_ready,
  output logic                result_valid,
  output logic [CH_W-1:0]     result_channel,
  output logic [31:0]         result_period,
  output logic [31:0]         result_high,
  output logic                result_timeout,
  output logic                busy
`ifdef DURATION_SCAN_DONE_EN
  ,
  output logic                scan_done
`endif
);

  typedef enum logic [2:0] {IDLE, SELECT, SYNC, MEASURE, REPORT} state_t;

  state_t              state, next_state;
  logic [CHANNELS-1:0] sync1, sync2;
  logic [CH_W-1:0]     ptr, sel;
  logic                found;
  logic                prev, cur, rise, fall;
  logic [31:0]         cnt, high_r;
  logic                timeout_hit, load_result, timed_out;
  int                  idx;

  assign cur         = sync2[ptr];
  assign rise        = !prev && cur;
  assign fall        = prev && !cur;
  assign timeout_hit = (cnt == 32'(TIMEOUT - 1));
  assign load_result = (next_state == REPORT) && (state != REPORT);
  assign timed_out   = !(state == MEASURE && rise);

  // First enabled channel strictly after ptr, wrapping; ptr itself is tried last.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (!found && enable_mask[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = SELECT;
      SELECT: begin
        if (!run)       next_state = IDLE;
        else if (found) next_state = SYNC;
      end
      SYNC: begin
        if (!run)             next_state = IDLE;
        else if (rise)        next_state = MEASURE;
        else if (timeout_hit) next_state = REPORT;
      end
      MEASURE: begin
        if (!run)                     next_state = IDLE;
        else if (rise || timeout_hit) next_state = REPORT;
      end
      REPORT:  if (result_ready) next_state = run ? SELECT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == REPORT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1          <= '0;
      sync2          <= '0;
      ptr            <= '0;
      prev           <= 1'b0;
      cnt            <= '0;
      high_r         <= '0;
      result_channel <= '0;
      result_period  <= '0;
      result_high    <= '0;
      result_timeout <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      case (state)
        SELECT: begin
          // Preload prev from the new channel so the switch itself is not an edge.
          ptr  <= sel;
          prev <= sync2[sel];
          cnt  <= '0;
        end
        SYNC: begin
          prev <= cur;
          cnt  <= rise ? 32'd1 : cnt + 32'd1;
        end
        MEASURE: begin
          prev <= cur;
          cnt  <= cnt + 32'd1;
          if (fall) high_r <= cnt;
        end
        default: ;
      endcase
      if (load_result) begin
        result_channel <= ptr;
        result_timeout <= timed_out;
        result_period  <= timed_out ? 32'd0 : cnt;
        result_high    <= timed_out ? 32'd0 : high_r;
      end
    end
  end

`ifdef DURATION_SCAN_DONE_EN
  logic [CH_W-1:0] last_idx;
  logic            last_flag;

  always_comb begin
    last_idx = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (enable_mask[i]) last_idx = CH_W'(i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         last_flag <= 1'b0;
    else if (state == SELECT && found) last_flag <= (sel == last_idx);
  end

  always_comb scan_done = result_valid && result_ready && last_flag;
`endif

endmodule

// File: tb/tb_duration_scan_controller.sv
// tb/tb_duration_scan_controller.sv - directed bench for duration_scan_controller
module tb_duration_scan_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  d = '0;
  logic [3:0]  enable_mask = '0;
  logic        run = 1'b0;
  logic        result_ready = 1'b1;
  logic        result_valid;
  logic [1:0]  result_channel;
  logic [31:0] result_period;
  logic [31:0] result_high;
  logic        result_timeout;
  logic        busy;
`ifdef DURATION_SCAN_DONE_EN
  logic        scan_done;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] hold_low = '0;
  int ph[4]  = '{0, 0, 0, 0};
  int hi[4]  = '{3, 2, 4, 5};
  int lo[4]  = '{5, 4, 3, 5};

  duration_scan_controller #(.CHANNELS(4), .TIMEOUT(50), .CH_W(2)) dut (
    .clock(clock),
    .reset(reset),
    .d(d),
    .enable_mask(enable_mask),
    .run(run),
    .result_ready(result_ready),
    .result_valid(result_valid),
    .result_channel(result_channel),
    .result_period(result_period),
    .result_high(result_high),
    .result_timeout(result_timeout),
    .busy(busy)
`ifdef DURATION_SCAN_DONE_EN
    ,
    .scan_done(scan_done)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      ph[i] = (ph[i] + 1) % (hi[i] + lo[i]);
      d[i]  = hold_low[i] ? 1'b0 : (ph[i] < hi[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (!result_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, 32'(result_valid), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    int seq_ch[4];
    int vcount;
    int lat;
    int stable;

    seq_ch = '{1, 3, 1, 3};

    idle_cycles(3);
    check("rst_valid",   32'(result_valid), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_channel", 32'(result_channel), 0);
    check("rst_period",  result_period, 0);
    check("rst_high",    result_high, 0);
    check("rst_timeout", 32'(result_timeout), 0);

    reset = 1'b0;
    enable_mask = 4'b0001;
    run = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_result($sformatf("ch0_r%0d", r));
      check($sformatf("ch0_r%0d_channel", r), 32'(result_channel), 0);
      check($sformatf("ch0_r%0d_period", r),  result_period, 8);
      check($sformatf("ch0_r%0d_high", r),    result_high, 3);
      check($sformatf("ch0_r%0d_timeout", r), 32'(result_timeout), 0);
    end

    idle_cycles(11);
    run = 1'b0;
    @(negedge clock);
    check("drop_busy",  32'(busy), 0);
    check("drop_valid", 32'(result_valid), 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (result_valid) vcount++;
    end
    check("drop_no_result", 32'(vcount), 0);

    enable_mask = 4'b1010;
    run = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_result($sformatf("rr%0d", r));
      check($sformatf("rr%0d_channel", r), 32'(result_channel), 32'(seq_ch[r]));
      check($sformatf("rr%0d_period", r),  result_period, 32'(hi[seq_ch[r]] + lo[seq_ch[r]]));
      check($sformatf("rr%0d_high", r),    result_high, 32'(hi[seq_ch[r]]));
    end

    idle_cycles(3);
    check("mid_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid",   32'(result_valid), 0);
    check("arst_busy",    32'(busy), 0);
    check("arst_channel", 32'(result_channel), 0);
    check("arst_period",  result_period, 0);
    check("arst_high",    result_high, 0);
    check("arst_timeout", 32'(result_timeout), 0);

    run = 1'b0;
    hold_low = 4'b0100;
    enable_mask = 4'b0100;
    result_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(2);
    run = 1'b1;
    @(negedge clock);
    check("to_busy", 32'(busy), 1);
    lat = 0;
    while (!result_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    check("to_latency", 32'(lat), 51);
    check("to_channel", 32'(result_channel), 2);
    check("to_timeout", 32'(result_timeout), 1);
    check("to_period",  result_period, 0);
    check("to_high",    result_high, 0);

    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (result_valid && result_channel == 2'd2 && result_timeout && result_period == 0)
        stable++;
    end
    check("hold_stable", 32'(stable), 10);
    result_ready = 1'b1;
    @(negedge clock);
    check("hold_release_valid", 32'(result_valid), 0);
    check("hold_release_busy",  32'(busy), 1);

`ifdef DURATION_SCAN_DONE_EN
    run = 1'b0;
    idle_cycles(2);
    hold_low = '0;
    enable_mask = 4'b0011;
    run = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_result($sformatf("sd%0d", r));
      check($sformatf("sd%0d_done", r), 32'(scan_done), 32'(result_channel == 2'd1));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
